nibble_serializer: RTL and testbench



---
 rtl/nibble_pkg.sv | 19 +
 rtl/nibble_select.sv | 24 ++
 rtl/nibble_serializer.sv | 103 ++++++++++
 tb/tb_nibble_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_pkg
// Brief    : Shared state encoding and widths for the nibble serializer.
// Revision : 1.0
// ============================================================================
package nibble_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } nib_state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_select.sv
`default_nettype none
// ============================================================================
// Module   : nibble_select
// Brief    : Combinational mux picking the half of hold shown in each phase.
// Revision : 1.0
// ============================================================================
module nibble_select
  import nibble_pkg::*;
#(
  parameter bit LO_FIRST = 1'b0
) (
  input  logic [BYTE_W-1:0] hold,
  input  logic              phase,
  output logic [NIB_W-1:0]  nibble
);

  logic w_take_lo;

  // phase 0 is the first nibble of the byte, phase 1 the second
  assign w_take_lo = phase ^ LO_FIRST;
  assign nibble    = w_take_lo ? hold[NIB_W-1:0] : hold[BYTE_W-1:NIB_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serializer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serializer
// Brief    : Byte-in, two-nibble-out serializer with valid/ready handshakes.
//            Optional out_parity port via NIBBLE_SERIALIZER_PARITY_EN.
// Revision : 1.0
// ============================================================================
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int LO_FIRST = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [NIB_W-1:0]  out_nibble,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              busy
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  nib_state_t        r_state;
  nib_state_t        w_state_nxt;
  logic [BYTE_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic              w_capture;
  logic              w_byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = FIRST;
      end
      FIRST: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = SECOND;
      end
      SECOND: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        // Accepting during the final nibble keeps one byte per two cycles
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? FIRST : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_capture   = in_valid & in_ready;
  assign w_byte_done = (r_state == SECOND) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_capture)   r_hold     <= in_data;
      if (w_byte_done) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
    end
  end

  assign byte_cnt = r_byte_cnt;

  nibble_select #(
    .LO_FIRST (LO_FIRST != 0)
  ) u_select (
    .hold   (r_hold),
    .phase  (r_state == SECOND),
    .nibble (out_nibble)
  );

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  assign out_parity = (^out_nibble) ^ out_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serializer
// Brief    : Directed bench for nibble_serializer (three parameterisations).
// Revision : 1.0
// ============================================================================
module tb_nibble_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       ir0, ov0, ol0, bz0;
  logic [3:0] on0;
  logic [7:0] bc0;
  logic       ir1, ov1, ol1, bz1;
  logic [3:0] on1;
  logic [7:0] bc1;
  logic       ir2, ov2, ol2, bz2;
  logic [3:0] on2;
  logic [1:0] bc2;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  logic       p0, p1, p2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serializer #(.LO_FIRST(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_nibble(on0), .out_last(ol0),
    .out_ready(out_ready), .byte_cnt(bc0), .busy(bz0)
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    , .out_parity(p0)
`endif
  );

  nibble_serializer #(.LO_FIRST(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_nibble(on1), .out_last(ol1),
    .out_ready(out_ready), .byte_cnt(bc1), .busy(bz1)
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    , .out_parity(p1)
`endif
  );

  nibble_serializer #(.LO_FIRST(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_nibble(on2), .out_last(ol2),
    .out_ready(out_ready), .byte_cnt(bc2), .busy(bz2)
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    , .out_parity(p2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: pending nibbles as {last, nibble}, one queue per emission order
  logic [4:0] q_hi[$];
  logic [4:0] q_lo[$];
  int unsigned m_cnt;
  logic m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_hi.delete();
      q_lo.delete();
      m_cnt = 0;
    end else begin
      m_rdy = (q_hi.size() == 0) || (q_hi.size() == 1 && out_ready);
      if (q_hi.size() != 0 && out_ready) begin
        if (q_hi[0][4]) m_cnt++;
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
      end
      if (in_valid && m_rdy) begin
        q_hi.push_back({1'b0, in_data[7:4]});
        q_hi.push_back({1'b1, in_data[3:0]});
        q_lo.push_back({1'b0, in_data[3:0]});
        q_lo.push_back({1'b1, in_data[7:4]});
      end
    end
  end

  logic e_valid, e_ready;

  always @(negedge clk) begin
    if (rst_n) begin
      e_valid = (q_hi.size() != 0);
      e_ready = (q_hi.size() == 0) || (q_hi.size() == 1 && out_ready);
      chk("u0.out_valid", ov0, e_valid);
      chk("u1.out_valid", ov1, e_valid);
      chk("u2.out_valid", ov2, e_valid);
      chk("u0.in_ready", ir0, e_ready);
      chk("u1.in_ready", ir1, e_ready);
      chk("u2.in_ready", ir2, e_ready);
      chk("u0.busy", bz0, e_valid);
      chk("u2.busy", bz2, e_valid);
      chk("u0.byte_cnt", bc0, m_cnt % 256);
      chk("u1.byte_cnt", bc1, m_cnt % 256);
      chk("u2.byte_cnt", bc2, m_cnt % 4);
      if (e_valid) begin
        chk("u0.out_nibble", on0, q_hi[0][3:0]);
        chk("u0.out_last", ol0, q_hi[0][4]);
        chk("u1.out_nibble", on1, q_lo[0][3:0]);
        chk("u1.out_last", ol1, q_lo[0][4]);
        chk("u2.out_nibble", on2, q_hi[0][3:0]);
        chk("u2.out_last", ol2, q_hi[0][4]);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        chk("u0.out_parity", p0, ^q_hi[0]);
        chk("u1.out_parity", p1, ^q_lo[0]);
        chk("u2.out_parity", p2, ^q_hi[0]);
`endif
      end
    end
  end

  // Drive one cycle of inputs, then return just after the falling edge
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.out_valid", ov0, 0);
    chk("rst.in_ready", ir0, 1);
    chk("rst.out_last", ol0, 0);
    chk("rst.out_nibble", on0, 0);
    chk("rst.busy", bz0, 0);
    chk("rst.byte_cnt", bc0, 0);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    chk("rst.out_parity", p0, 0);
`endif
    rst_n = 1'b1;

    // single byte
    step(1'b1, 8'hA5, 1'b1);  chk("single.in_ready", ir0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("single.nib1", on0, 4'hA); chk("single.last1", ol0, 0);
                              chk("single.valid1", ov0, 1); chk("single.lo_nib1", on1, 4'h5);
    step(1'b0, 8'h00, 1'b1);  chk("single.nib2", on0, 4'h5); chk("single.last2", ol0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("single.idle", ov0, 0); chk("single.cnt", bc0, 1);
                              chk("single.busy", bz0, 0);

    // back-to-back
    step(1'b1, 8'hA5, 1'b1);  chk("b2b.ready0", ir0, 1);
    step(1'b1, 8'h3C, 1'b1);  chk("b2b.nibA", on0, 4'hA); chk("b2b.ready1", ir0, 0);
    step(1'b1, 8'h3C, 1'b1);  chk("b2b.nib5", on0, 4'h5); chk("b2b.ready2", ir0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("b2b.nib3", on0, 4'h3); chk("b2b.ready3", ir0, 0);
    step(1'b0, 8'h00, 1'b1);  chk("b2b.nibC", on0, 4'hC); chk("b2b.lastC", ol0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("b2b.cnt", bc0, 3);

    // backpressure in FIRST; in_valid junk must be ignored
    step(1'b1, 8'h96, 1'b0);  chk("bp.accept", ir0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      chk($sformatf("bp.hold%0d", i), on0, 4'h9);
      chk($sformatf("bp.busy_ready%0d", i), ir0, 0);
    end
    step(1'b1, 8'hFF, 1'b1);  chk("bp.release", on0, 4'h9); chk("bp.release_ready", ir0, 0);
    step(1'b0, 8'h00, 1'b1);  chk("bp.nib6", on0, 4'h6); chk("bp.last6", ol0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("bp.cnt", bc0, 4);

    // LO_FIRST instance
    step(1'b1, 8'h7E, 1'b1);
    step(1'b0, 8'h00, 1'b1);  chk("lo.nibE", on1, 4'hE); chk("lo.lastE", ol1, 0);
    step(1'b0, 8'h00, 1'b1);  chk("lo.nib7", on1, 4'h7); chk("lo.last7", ol1, 1);
    step(1'b0, 8'h00, 1'b1);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
    step(1'b1, 8'h73, 1'b1);
    step(1'b0, 8'h00, 1'b1);  chk("par.nib7", p0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("par.nib3", p0, 1);
    step(1'b0, 8'h00, 1'b1);
`endif

    // asynchronous reset during a stalled SECOND
    step(1'b1, 8'hF0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);  chk("mid.second", ol0, 1); chk("mid.nib0", on0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("mid.valid", ov0, 0); chk("mid.cnt", bc0, 0); chk("mid.busy", bz0, 0);
    chk("mid.ready", ir0, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h12, 1'b1);
    step(1'b0, 8'h00, 1'b1);  chk("post.nib1", on0, 4'h1);
    step(1'b0, 8'h00, 1'b1);  chk("post.nib2", on0, 4'h2); chk("post.last", ol0, 1);
    step(1'b0, 8'h00, 1'b1);  chk("post.cnt", bc0, 1);

    // 2-bit counter wrap
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'(8'h40 + k), 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap.cnt%0d", k), bc2, wrap_exp[k]);
    end

    // mixed valid/ready patterns, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      step(((i * 7) % 5) != 0, 8'(i * 29 + 3), ((i * 11) % 3) != 0);
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
